// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_decoder
//  Purpose  : Recovers pixel/line position from VGA hsync_n/vsync_n, measures
//             line and frame periods, and locks onto a known timing.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int H_SYNC_PULSE   = 96,
    parameter int H_BACK_PORCH   = 48,
    parameter int H_VISIBLE_AREA = 640,
    parameter int H_TOTAL_EXP    = 800,
    parameter int V_SYNC_PULSE   = 2,
    parameter int V_BACK_PORCH   = 33,
    parameter int V_VISIBLE_AREA = 480,
    parameter int V_TOTAL_EXP    = 525,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        frame_start,
    output logic        locked,
    output logic        err
);

    localparam logic [10:0] c_CNT_MAX = 11'h7FF;
    localparam logic [10:0] c_H_START = 11'(H_SYNC_PULSE + H_BACK_PORCH);
    localparam logic [10:0] c_H_END   = 11'(H_SYNC_PULSE + H_BACK_PORCH + H_VISIBLE_AREA);
    localparam logic [10:0] c_V_START = 11'(V_SYNC_PULSE + V_BACK_PORCH);
    localparam logic [10:0] c_V_END   = 11'(V_SYNC_PULSE + V_BACK_PORCH + V_VISIBLE_AREA);
    localparam logic [10:0] c_H_TOTAL = 11'(H_TOTAL_EXP);
    localparam logic [10:0] c_V_TOTAL = 11'(V_TOTAL_EXP);
    localparam int          c_GW      = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [c_GW-1:0] c_LOCK_CNT = c_GW'(LOCK_FRAMES);
    localparam logic [c_GW-1:0] c_G_ONE    = c_GW'(1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic            hs_q, hs_d, vs_q, vs_d;
    logic [10:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [10:0]     line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic            vpend_q, vpend_d;
    logic [c_GW-1:0] gcnt_q, gcnt_d;
    state_t          state_q, state_d;
    logic            frame_bad_q, frame_bad_d;
    logic            frame_start_q, frame_start_d;
    logic            err_q, err_d;

    logic        w_h_fall, w_v_fall, w_h_sat, w_frame_evt;
    logic        w_line_bad, w_frame_good;
    logic [10:0] w_line_meas, w_frame_meas;

    // Edge detection uses the registered copy against the live input, so the
    // reset value of 1 makes a low hsync right after reset count as an edge.
    assign w_h_fall     = hs_q & ~hsync_n;
    assign w_v_fall     = vs_q & ~vsync_n;
    // The single cycle in which h_cnt advances onto its saturation value.
    assign w_h_sat      = ~w_h_fall & (h_cnt_q == (c_CNT_MAX - 11'd1));
    assign w_line_meas  = (h_cnt_q == c_CNT_MAX) ? c_CNT_MAX : h_cnt_q + 11'd1;
    assign w_frame_meas = (v_cnt_q == c_CNT_MAX) ? c_CNT_MAX : v_cnt_q + 11'd1;
    // A vsync edge coincident with the hsync edge counts as already pending.
    assign w_frame_evt  = w_h_fall & (vpend_q | w_v_fall);
    assign w_line_bad   = (w_h_fall & (w_line_meas != c_H_TOTAL)) | w_h_sat;
    assign w_frame_good = (w_frame_meas == c_V_TOTAL) & ~frame_bad_q & ~w_line_bad;

    // Line/frame counters, period capture and pending-vsync bookkeeping.
    always_comb begin
        hs_d          = hsync_n;
        vs_d          = vsync_n;
        h_cnt_d       = h_cnt_q;
        line_len_d    = line_len_q;
        v_cnt_d       = v_cnt_q;
        frame_lines_d = frame_lines_q;
        vpend_d       = vpend_q;
        frame_start_d = 1'b0;

        if (w_h_fall) begin
            h_cnt_d    = '0;
            line_len_d = w_line_meas;
        end else if (h_cnt_q != c_CNT_MAX) begin
            h_cnt_d = h_cnt_q + 11'd1;
        end

        if (w_h_sat) begin
            vpend_d = 1'b0;
        end else if (w_frame_evt) begin
            v_cnt_d       = '0;
            frame_lines_d = w_frame_meas;
            vpend_d       = 1'b0;
            frame_start_d = 1'b1;
        end else begin
            if (w_h_fall && (v_cnt_q != c_CNT_MAX)) begin
                v_cnt_d = v_cnt_q + 11'd1;
            end
            if (w_v_fall) begin
                vpend_d = 1'b1;
            end
        end
    end

    // Lock FSM: faults outrank frame boundaries; loss of hsync outranks all.
    always_comb begin
        state_d     = state_q;
        gcnt_d      = gcnt_q;
        err_d       = 1'b0;
        frame_bad_d = frame_bad_q;

        if (w_frame_evt) begin
            frame_bad_d = 1'b0;
        end else if (w_line_bad) begin
            frame_bad_d = 1'b1;
        end

        if (w_h_sat) begin
            err_d   = (state_q == ST_LOCKED);
            state_d = ST_SEARCH;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    // The partial frame seen before the first boundary is not judged.
                    if (w_frame_evt) begin
                        state_d = ST_ACQUIRE;
                        gcnt_d  = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_frame_evt) begin
                        if (w_frame_good) begin
                            gcnt_d = gcnt_q + c_G_ONE;
                            if ((gcnt_q + c_G_ONE) == c_LOCK_CNT) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            gcnt_d = '0;
                        end
                    end else if (w_line_bad) begin
                        gcnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_line_bad || (w_frame_evt && !w_frame_good)) begin
                        err_d   = 1'b1;
                        state_d = ST_ACQUIRE;
                        gcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    gcnt_d  = '0;
                end
            endcase
        end
    end

    // All state registers; reset has precedence over every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            vpend_q       <= 1'b0;
            gcnt_q        <= '0;
            state_q       <= ST_SEARCH;
            frame_bad_q   <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            vpend_q       <= vpend_d;
            gcnt_q        <= gcnt_d;
            state_q       <= state_d;
            frame_bad_q   <= frame_bad_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    assign x           = h_cnt_q - c_H_START;
    assign y           = v_cnt_q - c_V_START;
    assign locked      = (state_q == ST_LOCKED);
    assign de          = locked
                       & (h_cnt_q >= c_H_START) & (h_cnt_q < c_H_END)
                       & (v_cnt_q >= c_V_START) & (v_cnt_q < c_V_END);
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_start = frame_start_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- H_SYNC_PULSE, 96, hsync low width in clocks.
- H_BACK_PORCH, 48, clocks from hsync end to first visible pixel.
- H_VISIBLE_AREA, 640, visible pixels per line.
- H_TOTAL_EXP, 800, expected clocks per line.
- V_SYNC_PULSE, 2, vsync low width in lines.
- V_BACK_PORCH, 33, lines from vsync end to first visible line.
- V_VISIBLE_AREA, 480, visible lines per frame.
- V_TOTAL_EXP, 525, expected lines per frame.
- LOCK_FRAMES, 2, consecutive good frames required to lock.
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- clk, input, 1, pixel clock; the only clock.
- reset, input, 1, synchronous, active-high reset.
- hsync_n, input, 1, active-low horizontal sync, synchronous to clk.
- vsync_n, input, 1, active-low vertical sync, synchronous to clk.
- x, output, 11, recovered pixel column.
- y, output, 11, recovered pixel row.
- de, output, 1, visible-pixel qualifier.
- line_len, output, 11, last measured line period in clocks.
- frame_lines, output, 11, last measured frame length in lines.
- frame_start, output, 1, one-cycle pulse at each aligned frame boundary.
- locked, output, 1, timing matches expected values.
- err, output, 1, one-cycle pulse on any mismatch while LOCKED.

Function
REQ-003 hsync_n and vsync_n SHALL each be registered once (hs_d, vs_d). A falling edge is the cycle where the register is 1 and the live input is 0.
REQ-004 On an hsync falling edge, h_cnt SHALL load 0 and line_len SHALL capture h_cnt+1. Otherwise h_cnt SHALL increment, saturating at 2047. For 800-clock lines, line_len=800.
REQ-005 A vsync falling edge SHALL set vpend. A vsync edge in the same cycle as an hsync edge SHALL be treated as already set.
REQ-006 On an hsync edge with vpend set (after REQ-005), the block SHALL:
- load v_cnt to 0;
- capture v_cnt+1 into frame_lines;
- clear vpend;
- pulse frame_start for that one cycle.
REQ-007 On an hsync edge without vpend, v_cnt SHALL increment, saturating at 2047. Cycles with no hsync edge SHALL NOT change v_cnt.
REQ-008 Outputs x and y SHALL be computed from the counters (11-bit, wrap permitted outside the window):
- x = h_cnt - (H_SYNC_PULSE+H_BACK_PORCH);
- y = v_cnt - (V_SYNC_PULSE+V_BACK_PORCH).
REQ-009 de SHALL be 1 only when all of the following hold:
- locked=1;
- H_SYNC_PULSE+H_BACK_PORCH <= h_cnt < that sum + H_VISIBLE_AREA;
- V_SYNC_PULSE+V_BACK_PORCH <= v_cnt < that sum + V_VISIBLE_AREA.
REQ-010 The FSM SHALL have three states: SEARCH, ACQUIRE and LOCKED. locked=1 only in LOCKED.
REQ-011 Line faults: a line is bad when a captured line_len is not H_TOTAL_EXP, or when h_cnt reaches 2047. A frame is good when its frame_lines equals V_TOTAL_EXP and none of its lines were bad.
REQ-012 Good-frame counter gcnt (range 0..LOCK_FRAMES): it SHALL be cleared on entry to SEARCH and on any bad line.
REQ-013 SEARCH -> ACQUIRE SHALL occur on the first frame_start. The partial frame before it is not evaluated.
REQ-014 In ACQUIRE, at each frame_start:
- if the frame was good, gcnt increments, and when it reaches LOCK_FRAMES the FSM moves to LOCKED;
- if the frame was bad, gcnt clears and the FSM stays in ACQUIRE.
REQ-015 In LOCKED, a bad line or bad frame SHALL pulse err for one cycle and move the FSM to ACQUIRE on the next clock.
REQ-016 h_cnt reaching 2047 SHALL force SEARCH from any state, clear vpend, and pulse err only if the FSM was LOCKED.
REQ-017 When a faulting event and frame_start coincide, the fault SHALL take priority.

Reset
REQ-018 While reset=1 at a clk edge, the block SHALL load:
- hs_d=1, vs_d=1;
- h_cnt=0, v_cnt=0, line_len=0, frame_lines=0;
- vpend=0, gcnt=0, state=SEARCH.
REQ-019 Output values SHALL follow from REQ-018: de=0, locked=0, frame_start=0, err=0, x=1904, y=2013.
REQ-020 Reset SHALL override all other events, including reset asserted mid-frame in LOCKED.
REQ-021 If hsync_n=0 in the first cycle after reset release, that cycle SHALL count as an hsync falling edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Nominal lock: 800x525 timing with syncs at line/frame starts -> ACQUIRE at the first frame_start; locked=1 from the third frame_start; line_len=800, frame_lines=525.
- Visible window in LOCKED: h_cnt=144, v_cnt=35 -> de=1, x=0, y=0. h_cnt=783, v_cnt=514 -> de=1, x=639, y=479. Next cycle de=0.
- Bad line: one 801-clock line while LOCKED -> line_len=801, one-cycle err, locked=0 next cycle, state ACQUIRE. After two good frames, relock.
- Lost sync: hsync_n held high for 2100 clocks -> h_cnt=2047, state SEARCH, locked=0, err pulses once.
- Vsync alignment: vsync edge coincident with an hsync edge -> frame_start that cycle, v_cnt=0. Vsync edge at h_cnt=400 -> frame_start and v_cnt=0 at the following hsync edge.
- Reset mid-frame in LOCKED -> all registers and outputs at REQ-018/REQ-019 values on the next cycle.
